// File: rtl/data_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache that sits
// between the MEM stage and SRAM_Controller. One word per line, one lru bit per set.
//
// Handshake: a request (mem_r_en / mem_w_en) is held stable by the pipeline while
// ready=0; it is complete on the first rising edge where ready=1. Toward SRAM, an
// access is held (sram_r_en / sram_w_en) until the edge where sram_ready=1.
module data_cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SET_LOG2 = 6,
  parameter int TAG_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int SETS = 1 << SET_LOG2;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state, state_nxt;

  // Storage: valid and lru are reset, tag and data arrays are not.
  logic [SETS-1:0]   valid_w0, valid_w1, lru;
  logic [TAG_W-1:0]  tag_w0  [SETS];
  logic [TAG_W-1:0]  tag_w1  [SETS];
  logic [DATA_W-1:0] data_w0 [SETS];
  logic [DATA_W-1:0] data_w1 [SETS];

  logic [SET_LOG2-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                unused_addr;
  logic                is_read, is_write;
  logic                hit0, hit1, hit, hit_way, victim;
  logic                rd_hit, fill_en, wr_done;

  assign idx         = address[SET_LOG2+1:2];
  assign tag         = address[TAG_W+SET_LOG2+1:SET_LOG2+2];
  assign unused_addr = ^{address[1:0], address[ADDR_W-1:TAG_W+SET_LOG2+2]};

  // Read wins when both enables are high; wdata is then ignored.
  assign is_read  = mem_r_en;
  assign is_write = mem_w_en & ~mem_r_en;

  assign hit0    = valid_w0[idx] && (tag_w0[idx] == tag);
  assign hit1    = valid_w1[idx] && (tag_w1[idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;   // meaningful only when hit=1; ways never share a tag

  // Fill target: an invalid way first (way 0 preferred), otherwise the LRU way.
  assign victim = ~valid_w0[idx] ? 1'b0 : (~valid_w1[idx] ? 1'b1 : lru[idx]);

  assign rd_hit  = (state == IDLE) && is_read && hit;
  assign fill_en = (state == READ_MISS) && sram_ready;
  assign wr_done = (state == WRITE) && sram_ready;

  assign sram_addr  = address;
  assign sram_wdata = wdata;

  // State register; reset abandons any in-flight fill or write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and outputs; SRAM enables depend on state only.
  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_read) begin
          if (hit) begin
            rdata = hit0 ? data_w0[idx] : data_w1[idx];
          end else begin
            ready     = 1'b0;
            state_nxt = READ_MISS;
          end
        end else if (is_write) begin
          ready     = 1'b0;
          state_nxt = WRITE;
        end
      end
      READ_MISS: begin
        sram_r_en = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          rdata     = sram_rdata;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        sram_w_en = 1'b1;
        ready     = sram_ready;
        if (sram_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The pipeline sees an idle, ready cache for the whole reset.
    if (rst) begin
      ready = 1'b1;
      rdata = '0;
    end
  end

  // Valid and lru bookkeeping: hits and fills make the touched way MRU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w0 <= '0;
      valid_w1 <= '0;
      lru      <= '0;
    end else begin
      if (rd_hit || (wr_done && hit)) lru[idx] <= ~hit_way;
      if (fill_en) begin
        if (victim) valid_w1[idx] <= 1'b1;
        else        valid_w0[idx] <= 1'b1;
        lru[idx] <= ~victim;
      end
    end
  end

  // Tag/data arrays: fill on read-miss completion, update on write hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        tag_w1[idx]  <= tag;
        data_w1[idx] <= sram_rdata;
      end else begin
        tag_w0[idx]  <= tag;
        data_w0[idx] <= sram_rdata;
      end
    end
    if (wr_done && hit) begin
      if (hit_way) data_w1[idx] <= wdata;
      else         data_w0[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: SRAM_Controller model with variable latency,
// recency-list reference model of the cache, expected queue and a monitor.
module tb_data_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_r_en, sram_w_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_ready;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  data_cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_r_en  (sram_r_en),
    .sram_w_en  (sram_w_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] w);
    return {w[15:0] ^ 16'hA5C3, w[15:0] + 16'h1234};
  endfunction

  // ---------------- SRAM_Controller model ----------------
  logic [31:0] env_mem [logic [31:0]];
  int          sram_lat = 7;
  int          sram_cnt;

  function automatic logic [31:0] env_read(input logic [31:0] w);
    if (env_mem.exists(w)) return env_mem[w];
    return dflt(w);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ready <= 1'b0;
      sram_rdata <= 32'h0;
      sram_cnt   <= 0;
    end else if (sram_ready) begin
      sram_ready <= 1'b0;
      sram_cnt   <= 0;
      if (sram_w_en) env_mem[sram_addr >> 2] = sram_wdata;
    end else if (sram_r_en || sram_w_en) begin
      if (sram_cnt + 1 >= sram_lat) begin
        sram_ready <= 1'b1;
        sram_rdata <= env_read(sram_addr >> 2);
      end else begin
        sram_cnt <= sram_cnt + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Memory contents plus, per set, an MRU/LRU list of up to two resident tags.
  logic [31:0] ref_mem [logic [31:0]];
  logic [10:0] m_mru [64];
  logic [10:0] m_lru [64];
  int          m_cnt [64];

  function automatic logic [31:0] ref_read(input logic [31:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return dflt(w);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endfunction

  // Returns 1 on hit (and makes the tag MRU); on miss inserts when fill=1.
  function automatic bit model_access(input logic [31:0] a, input bit fill);
    logic [5:0]  s;
    logic [10:0] t;
    s = a[7:2];
    t = a[18:8];
    if (m_cnt[s] > 0 && m_mru[s] == t) return 1'b1;
    if (m_cnt[s] == 2 && m_lru[s] == t) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = t;
      return 1'b1;
    end
    if (fill) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = t;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end
    return 1'b0;
  endfunction

  // ---------------- scoreboard queue: {is_read, hit, addr, data} ----------------
  logic [65:0] exp_q[$];

  // ---------------- driver ----------------
  task automatic do_req(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    bit          hit;
    logic [31:0] ed;
    int          waited;
    @(posedge clk); #1;
    hit = model_access(a, r);
    if (r) ed = ref_read(a >> 2);
    else begin
      ed = d;
      ref_mem[a >> 2] = d;
    end
    exp_q.push_back({r, hit, a, ed});
    sram_lat = lat;
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wdata    = d;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready && waited < 64);
    if (!ready) begin
      chk("req_timeout", 32'd0, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  // ---------------- monitor ----------------
  int stall, rd_seen, wr_seen;

  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) begin
      stall   = 0;
      rd_seen = 0;
      wr_seen = 0;
    end else if (mem_r_en || mem_w_en) begin
      if (sram_r_en) rd_seen++;
      if (sram_w_en) wr_seen++;
      if (!ready) stall++;
      else if (exp_q.size() == 0) chk("unexpected_txn", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sram_addr", sram_addr, e[63:32]);
        chk("no_wr_pulse_on_read", {31'd0, wr_seen != 0}, {31'd0, ~e[65]});
        if (e[65]) begin
          chk("rdata", rdata, e[31:0]);
          if (e[64]) begin
            chk("hit_wait_cycles", stall, 32'd0);
            chk("hit_sram_reads", rd_seen, 32'd0);
          end else begin
            chk("miss_stalled", {31'd0, stall != 0}, 32'd1);
            chk("miss_sram_read", {31'd0, rd_seen != 0}, 32'd1);
          end
        end else begin
          chk("wr_stalled", {31'd0, stall != 0}, 32'd1);
          chk("wr_no_sram_read", rd_seen, 32'd0);
          chk("sram_wdata", sram_wdata, e[31:0]);
        end
        stall   = 0;
        rd_seen = 0;
        wr_seen = 0;
      end
    end else begin
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_rdata", rdata, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'h0;
    wdata    = 32'h0;
    env_mem[32'h400 >> 2] = 32'hDEADBEEF;
    ref_mem[32'h400 >> 2] = 32'hDEADBEEF;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("reset_sram_w_en", {31'd0, sram_w_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Miss fill then hit.
    do_req(1, 0, 32'h400, 32'h0, 7);
    do_req(1, 0, 32'h400, 32'h0, 7);
    // Write hit updates the cached word.
    do_req(0, 1, 32'h400, 32'h12345678, 7);
    do_req(1, 0, 32'h400, 32'h0, 7);
    // Write miss does not allocate.
    do_req(0, 1, 32'h800, 32'hA5A5A5A5, 7);
    do_req(1, 0, 32'h800, 32'h0, 7);
    // LRU eviction within set 0.
    do_req(1, 0, 32'h000, 32'h0, 3);
    do_req(1, 0, 32'h100, 32'h0, 3);
    do_req(1, 0, 32'h000, 32'h0, 3);
    do_req(1, 0, 32'h200, 32'h0, 3);
    do_req(1, 0, 32'h000, 32'h0, 3);
    do_req(1, 0, 32'h100, 32'h0, 3);

    // Reset in the third cycle of a read miss.
    @(posedge clk); #1;
    sram_lat = 7;
    mem_r_en = 1'b1;
    address  = 32'h300;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_rdata", rdata, 32'd0);
    mem_r_en = 1'b0;
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1, 0, 32'h000, 32'h0, 4);

    // Both enables high: treated as a read miss.
    do_req(1, 1, 32'h040, 32'h77777777, 7);

    // Randomized traffic over a few sets and tags.
    for (int i = 0; i < 200; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      do_req(op != 2, op >= 2, a, $urandom, $urandom_range(1, 8));
    end

    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
